axim_mem_responder: RTL and testbench
=====================================

# axim_mem_responder

Memory-side responder for the vector core's MCU <=> AXIM control interface: it accepts read and write transfer requests (offset, size, start), sources the read data stream, sinks the write data stream with byte strobes, and signals completion with done pulses. It is backed by an internal word-addressed RAM. The block replaces the AXI master plus external memory in core-level simulation and on-chip test builds. Read and write channels run independently and concurrently.

## Interface

- C_M_AXI_ADDR_WIDTH, 32, byte-offset width
- C_M_AXI_DATA_WIDTH, 32, stream data width; power of two, at least 8
- C_XFER_SIZE_WIDTH, 32, transfer-size width in bytes
- MEM_DEPTH, 1024, RAM depth in words; power of two
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- ctrl_raddr_offset_i  in  C_M_AXI_ADDR_WIDTH  read start byte offset
- ctrl_rxfer_size_i  in  C_XFER_SIZE_WIDTH  read length in bytes
- ctrl_rstart_i  in  1  read request; sampled only in R_IDLE
- ctrl_rdone_o  out  1  one-cycle read-complete pulse
- rd_tdata_o  out  C_M_AXI_DATA_WIDTH  read beat data
- rd_tvalid_o  out  1  read beat valid
- rd_tready_i  in  1  consumer ready
- rd_tlast_o  out  1  final read beat
- ctrl_waddr_offset_i  in  C_M_AXI_ADDR_WIDTH  write start byte offset
- ctrl_wxfer_size_i  in  C_XFER_SIZE_WIDTH  write length in bytes
- ctrl_wstart_i  in  1  write request; sampled only in W_IDLE
- ctrl_wstrb_msk_en_i  in  1  strobe-mask enable, latched with ctrl_wstart_i
- ctrl_wdone_o  out  1  one-cycle write-complete pulse
- wr_tdata_i  in  C_M_AXI_DATA_WIDTH  write beat data
- wr_tvalid_i  in  1  write beat valid
- wr_tready_o  out  1  responder ready
- wr_tstrb_msk_i  in  C_M_AXI_DATA_WIDTH/8  per-beat byte enables

## Operation

- BPW = C_M_AXI_DATA_WIDTH/8. Word index = (offset >> log2(BPW)) mod MEM_DEPTH; low offset bits ignored. Beats = size >> log2(BPW) (remainder bytes dropped).
- Index increments by 1 per beat, wraps MEM_DEPTH-1 -> 0.
- Read FSM: R_IDLE -> (rstart) R_STREAM -> (handshake on last beat) R_DONE -> R_IDLE. Zero beats: R_IDLE -> R_DONE directly, no tvalid.
- R_STREAM: RAM read port prefetches the next word whenever output register empty or handshake occurs; rd_tvalid_o/rd_tdata_o/rd_tlast_o held stable while rd_tready_i low.
- Write FSM: W_IDLE -> (wstart) W_STREAM -> (handshake on last beat) W_DONE -> W_IDLE; zero beats go straight to W_DONE. wr_tready_o = 1 exactly in W_STREAM.
- Each write handshake writes byte k of the word iff (msk_en_latched ? wr_tstrb_msk_i[k] : 1).
- Start asserted outside IDLE is ignored (not queued). Beat counters are C_XFER_SIZE_WIDTH wide.
- Same-cycle read and write of same word: read returns old data; write visible to reads issued the following cycle.
- RAM contents are not cleared by reset.

## Timing

- Reset: all outputs 0, both FSMs IDLE; reset mid-transfer aborts immediately without a done pulse, partial writes already committed stay.
- rstart sampled at edge N: RAM read at N+1, rd_tvalid_o high after edge N+2 (2-cycle latency).
- With rd_tready_i held high: one beat per cycle, no bubbles.
- Last read handshake at edge M: rd_tvalid_o low and ctrl_rdone_o high after M, for one cycle; next rstart accepted at edge M+2.
- wstart at edge N: wr_tready_o high after N. Last write handshake at edge M: wr_tready_o low, ctrl_wdone_o high for one cycle after M.
- Zero-size request at edge N: done pulse high after N+1 (R_IDLE -> R_DONE at N, pulse registered).

## Test plan

- Write 4 beats 0x11111111..0x44444444 at offset 0x40, msk_en=0 -> wdone one cycle after 4th handshake; read 16 bytes at 0x40 returns same 4 words, tlast on 4th, rdone after.
- Read 8 beats with rd_tready_i toggling 1,0,1,0 -> data stable during stalls, exactly 8 handshakes, ordered, single rdone.
- Write msk_en=1, strb=4'b0101, data 0xAABBCCDD over word 0xFFFFFFFF -> readback 0xFFBBFFDD.
- Write offset (MEM_DEPTH-1)*BPW, size 2*BPW -> second beat lands at word 0; readback confirms wrap.
- Concurrent read and write of disjoint regions, plus rstart pulse mid-read -> both complete, second rstart ignored.
- Assert reset during beat 3 of an 8-beat read -> all outputs 0 next cycle, no rdone; fresh read afterwards starts cleanly.

Source files
------------

// File: rtl/axim_mem_responder_if.sv
// Bundles the request, read-stream and write-stream signals of the memory responder.
// The master modport is the requester side; the slave modport is the memory side.
interface axim_mem_responder_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH  = 32
);
    logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_raddr_offset_i;
    logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_rxfer_size_i;
    logic                            ctrl_rstart_i;
    logic                            ctrl_rdone_o;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rd_tdata_o;
    logic                            rd_tvalid_o;
    logic                            rd_tready_i;
    logic                            rd_tlast_o;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_waddr_offset_i;
    logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_wxfer_size_i;
    logic                            ctrl_wstart_i;
    logic                            ctrl_wstrb_msk_en_i;
    logic                            ctrl_wdone_o;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wr_tdata_i;
    logic                            wr_tvalid_i;
    logic                            wr_tready_o;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wr_tstrb_msk_i;

    modport slave (
        input  ctrl_raddr_offset_i, ctrl_rxfer_size_i, ctrl_rstart_i,
        output ctrl_rdone_o, rd_tdata_o, rd_tvalid_o, rd_tlast_o,
        input  rd_tready_i,
        input  ctrl_waddr_offset_i, ctrl_wxfer_size_i, ctrl_wstart_i, ctrl_wstrb_msk_en_i,
        output ctrl_wdone_o, wr_tready_o,
        input  wr_tdata_i, wr_tvalid_i, wr_tstrb_msk_i
    );

    modport master (
        output ctrl_raddr_offset_i, ctrl_rxfer_size_i, ctrl_rstart_i,
        input  ctrl_rdone_o, rd_tdata_o, rd_tvalid_o, rd_tlast_o,
        output rd_tready_i,
        output ctrl_waddr_offset_i, ctrl_wxfer_size_i, ctrl_wstart_i, ctrl_wstrb_msk_en_i,
        input  ctrl_wdone_o, wr_tready_o,
        output wr_tdata_i, wr_tvalid_i, wr_tstrb_msk_i
    );
endinterface

// File: rtl/axim_mem_responder.sv
// Memory-side responder: independent read and write streaming FSMs over a word-addressed RAM.
// Reads use a RAM output stage plus an output register, giving two-cycle latency and full throughput.
module axim_mem_responder #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int MEM_DEPTH          = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    axim_mem_responder_if.slave  bus
);
    localparam int BPW    = C_M_AXI_DATA_WIDTH / 8;
    localparam int OFF_SH = $clog2(BPW);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int DW     = C_M_AXI_DATA_WIDTH;
    localparam int XW     = C_XFER_SIZE_WIDTH;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [XW-1:0]    CNT_ONE = XW'(1);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_STREAM = 2'd1, R_DONE = 2'd2} r_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_STREAM = 2'd1, W_DONE = 2'd2} w_state_e;

    logic [DW-1:0]    mem_q [MEM_DEPTH];
    logic [DW-1:0]    ram_rdata_q;

    r_state_e         r_state_q;
    logic [IDX_W-1:0] r_idx_q;
    logic [XW-1:0]    r_beats_q;
    logic [XW-1:0]    r_issue_q;
    logic             r_zero_q;
    logic             ram_vld_q;
    logic             ram_last_q;
    logic [DW-1:0]    rd_tdata_q;
    logic             rd_tvalid_q;
    logic             rd_tlast_q;
    logic             rdone_q;

    w_state_e         w_state_q;
    logic [IDX_W-1:0] w_idx_q;
    logic [XW-1:0]    w_beats_q;
    logic [XW-1:0]    w_cnt_q;
    logic             w_zero_q;
    logic             w_msk_en_q;
    logic             wr_tready_q;
    logic             wdone_q;

    logic [XW-1:0]    r_start_beats_s;
    logic [XW-1:0]    w_start_beats_s;
    logic             r_adv_s;
    logic             r_hs_s;
    logic             ram_re_s;
    logic             w_hs_s;
    logic             mem_we_s;
    logic [BPW-1:0]   wr_be_s;
    logic             unused_s;

    assign r_start_beats_s = bus.ctrl_rxfer_size_i >> OFF_SH;
    assign w_start_beats_s = bus.ctrl_wxfer_size_i >> OFF_SH;
    assign r_adv_s  = !rd_tvalid_q || bus.rd_tready_i;
    assign r_hs_s   = rd_tvalid_q && bus.rd_tready_i;
    // Fetch the next word only when the RAM stage will be free after this edge.
    assign ram_re_s = (r_state_q == R_STREAM) && (r_issue_q != r_beats_q) && (!ram_vld_q || r_adv_s);
    assign w_hs_s   = wr_tready_q && bus.wr_tvalid_i;
    assign mem_we_s = w_hs_s && !reset;
    assign wr_be_s  = w_msk_en_q ? bus.wr_tstrb_msk_i : {BPW{1'b1}};
    assign unused_s = ^{bus.ctrl_raddr_offset_i, bus.ctrl_waddr_offset_i,
                        bus.ctrl_rxfer_size_i, bus.ctrl_wxfer_size_i};

    assign bus.ctrl_rdone_o = rdone_q;
    assign bus.rd_tdata_o   = rd_tdata_q;
    assign bus.rd_tvalid_o  = rd_tvalid_q;
    assign bus.rd_tlast_o   = rd_tlast_q;
    assign bus.ctrl_wdone_o = wdone_q;
    assign bus.wr_tready_o  = wr_tready_q;

    // RAM array: one synchronous read port, one byte-enabled write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_re_s) begin
            ram_rdata_q <= mem_q[r_idx_q];
        end
        for (int k = 0; k < BPW; k++) begin
            if (mem_we_s && wr_be_s[k]) begin
                mem_q[w_idx_q][k*8 +: 8] <= bus.wr_tdata_i[k*8 +: 8];
            end
        end
    end

    // Read FSM with RAM stage and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= R_IDLE;
            r_idx_q     <= '0;
            r_beats_q   <= '0;
            r_issue_q   <= '0;
            r_zero_q    <= 1'b0;
            ram_vld_q   <= 1'b0;
            ram_last_q  <= 1'b0;
            rd_tdata_q  <= '0;
            rd_tvalid_q <= 1'b0;
            rd_tlast_q  <= 1'b0;
            rdone_q     <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    rdone_q   <= 1'b0;
                    ram_vld_q <= 1'b0;
                    if (bus.ctrl_rstart_i) begin
                        r_idx_q   <= bus.ctrl_raddr_offset_i[OFF_SH +: IDX_W];
                        r_beats_q <= r_start_beats_s;
                        r_issue_q <= '0;
                        r_zero_q  <= (r_start_beats_s == '0);
                        r_state_q <= (r_start_beats_s == '0) ? R_DONE : R_STREAM;
                    end
                end
                R_STREAM: begin
                    if (ram_re_s) begin
                        r_idx_q    <= r_idx_q + IDX_ONE;
                        r_issue_q  <= r_issue_q + CNT_ONE;
                        ram_last_q <= (r_issue_q == r_beats_q - CNT_ONE);
                    end
                    ram_vld_q <= ram_re_s || (ram_vld_q && !r_adv_s);
                    if (r_hs_s && rd_tlast_q) begin
                        rd_tvalid_q <= 1'b0;
                        rd_tlast_q  <= 1'b0;
                        rdone_q     <= 1'b1;
                        r_state_q   <= R_DONE;
                    end else if (r_adv_s) begin
                        rd_tvalid_q <= ram_vld_q;
                        rd_tdata_q  <= ram_rdata_q;
                        rd_tlast_q  <= ram_vld_q && ram_last_q;
                    end
                end
                R_DONE: begin
                    // A zero-length request raises its pulse here; a streamed one drops it.
                    rdone_q   <= r_zero_q;
                    r_state_q <= R_IDLE;
                end
                default: begin
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // Write FSM: accepts beats while in W_STREAM and steps the word index per handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q   <= W_IDLE;
            w_idx_q     <= '0;
            w_beats_q   <= '0;
            w_cnt_q     <= '0;
            w_zero_q    <= 1'b0;
            w_msk_en_q  <= 1'b0;
            wr_tready_q <= 1'b0;
            wdone_q     <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    wdone_q <= 1'b0;
                    if (bus.ctrl_wstart_i) begin
                        w_idx_q     <= bus.ctrl_waddr_offset_i[OFF_SH +: IDX_W];
                        w_beats_q   <= w_start_beats_s;
                        w_cnt_q     <= '0;
                        w_msk_en_q  <= bus.ctrl_wstrb_msk_en_i;
                        w_zero_q    <= (w_start_beats_s == '0);
                        wr_tready_q <= (w_start_beats_s != '0);
                        w_state_q   <= (w_start_beats_s == '0) ? W_DONE : W_STREAM;
                    end
                end
                W_STREAM: begin
                    if (w_hs_s) begin
                        w_idx_q <= w_idx_q + IDX_ONE;
                        w_cnt_q <= w_cnt_q + CNT_ONE;
                        if (w_cnt_q == w_beats_q - CNT_ONE) begin
                            wr_tready_q <= 1'b0;
                            wdone_q     <= 1'b1;
                            w_state_q   <= W_DONE;
                        end
                    end
                end
                W_DONE: begin
                    wdone_q   <= w_zero_q;
                    w_state_q <= W_IDLE;
                end
                default: begin
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axim_mem_responder.sv
// Directed bench for axim_mem_responder: write/read round trips, stalls, strobes, wrap,
// concurrency, zero-length requests and reset in mid-stream.
module tb_axim_mem_responder;
    logic clk = 1'b0;
    logic reset;
    int   vecs = 0;
    int   errs = 0;
    int   rdone_cnt = 0;
    int   wdone_cnt = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rbuf [16];
    logic        rlast [16];
    int          n_rd, first_valid, first_hs, last_hs, viol;
    bit          got_last;

    axim_mem_responder_if #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
                            .C_XFER_SIZE_WIDTH(32)) bus ();

    axim_mem_responder #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
                         .C_XFER_SIZE_WIDTH(32), .MEM_DEPTH(1024))
        dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ctrl_rdone_o === 1'b1) rdone_cnt++;
        if (bus.ctrl_wdone_o === 1'b1) wdone_cnt++;
    end

    task automatic do_write(input logic [31:0] off, input logic [31:0] nbytes, input logic msk);
        int c;
        bus.ctrl_waddr_offset_i = off;
        bus.ctrl_wxfer_size_i   = nbytes;
        bus.ctrl_wstrb_msk_en_i = msk;
        bus.ctrl_wstart_i       = 1'b1;
        @(posedge clk); #1;
        bus.ctrl_wstart_i = 1'b0;
        for (int b = 0; b < int'(nbytes / 32'd4); b++) begin
            bus.wr_tvalid_i    = 1'b1;
            bus.wr_tdata_i     = wbuf[b];
            bus.wr_tstrb_msk_i = sbuf[b];
            c = 0;
            while (bus.wr_tready_o !== 1'b1 && c < 50) begin
                @(posedge clk); #1;
                c++;
            end
            if (c >= 50) begin
                vecs++; errs++;
                $display("FAIL wr_timeout: beat %0d never accepted (wr_tready_o=%b, required 1)", b, bus.wr_tready_o);
                break;
            end
            @(posedge clk); #1;
        end
        bus.wr_tvalid_i = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] off, input logic [31:0] nbytes, input bit toggle);
        bit          stalled;
        logic [31:0] pd;
        logic        pl;
        n_rd = 0; first_valid = -1; first_hs = -1; last_hs = -1; viol = 0; got_last = 1'b0;
        stalled = 1'b0; pd = 32'h0; pl = 1'b0;
        bus.ctrl_raddr_offset_i = off;
        bus.ctrl_rxfer_size_i   = nbytes;
        bus.ctrl_rstart_i       = 1'b1;
        @(posedge clk); #1;
        bus.ctrl_rstart_i = 1'b0;
        for (int c = 0; c < 300 && !got_last; c++) begin
            bus.rd_tready_i = toggle ? (c % 2 == 0) : 1'b1;
            if (stalled && (bus.rd_tvalid_o !== 1'b1 || bus.rd_tdata_o !== pd || bus.rd_tlast_o !== pl))
                viol++;
            if (bus.rd_tvalid_o === 1'b1 && first_valid < 0) first_valid = c;
            if (bus.rd_tvalid_o === 1'b1 && bus.rd_tready_i === 1'b1 && n_rd < 16) begin
                rbuf[n_rd]  = bus.rd_tdata_o;
                rlast[n_rd] = bus.rd_tlast_o;
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                n_rd++;
                if (bus.rd_tlast_o === 1'b1) got_last = 1'b1;
            end
            stalled = (bus.rd_tvalid_o === 1'b1) && (bus.rd_tready_i !== 1'b1);
            pd = bus.rd_tdata_o;
            pl = bus.rd_tlast_o;
            @(posedge clk); #1;
        end
        bus.rd_tready_i = 1'b0;
        if (!got_last) begin
            vecs++; errs++;
            $display("FAIL rd_timeout: no tlast handshake (beats seen %0d, required a final beat)", n_rd);
        end
    endtask

    task automatic test_reset();
        vecs++; if (bus.rd_tvalid_o !== 1'b0) begin errs++; $display("FAIL rst_tvalid: got %b want 0", bus.rd_tvalid_o); end
        vecs++; if (bus.rd_tdata_o !== 32'h0) begin errs++; $display("FAIL rst_tdata: got %h want 0", bus.rd_tdata_o); end
        vecs++; if (bus.rd_tlast_o !== 1'b0) begin errs++; $display("FAIL rst_tlast: got %b want 0", bus.rd_tlast_o); end
        vecs++; if (bus.ctrl_rdone_o !== 1'b0) begin errs++; $display("FAIL rst_rdone: got %b want 0", bus.ctrl_rdone_o); end
        vecs++; if (bus.ctrl_wdone_o !== 1'b0) begin errs++; $display("FAIL rst_wdone: got %b want 0", bus.ctrl_wdone_o); end
        vecs++; if (bus.wr_tready_o !== 1'b0) begin errs++; $display("FAIL rst_wready: got %b want 0", bus.wr_tready_o); end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h11111111 * (i + 1); sbuf[i] = 4'hF; end
        do_write(32'h40, 32'd16, 1'b0);
        vecs++; if (bus.ctrl_wdone_o !== 1'b1) begin errs++; $display("FAIL wr_done: got %b want 1", bus.ctrl_wdone_o); end
        vecs++; if (bus.wr_tready_o !== 1'b0) begin errs++; $display("FAIL wr_ready_low: got %b want 0", bus.wr_tready_o); end
        @(posedge clk); #1;
        vecs++; if (bus.ctrl_wdone_o !== 1'b0) begin errs++; $display("FAIL wr_done_pulse: got %b want 0", bus.ctrl_wdone_o); end
        do_read(32'h40, 32'd16, 1'b0);
        vecs++; if (n_rd !== 4) begin errs++; $display("FAIL rd_beats: got %0d want 4", n_rd); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (rbuf[i] !== 32'h11111111 * (i + 1)) begin errs++; $display("FAIL rd_data[%0d]: got %h want %h", i, rbuf[i], 32'h11111111 * (i + 1)); end
            vecs++; if (rlast[i] !== (i == 3)) begin errs++; $display("FAIL rd_last[%0d]: got %b want %b", i, rlast[i], (i == 3)); end
        end
        vecs++; if (first_valid !== 2) begin errs++; $display("FAIL rd_latency: got %0d want 2", first_valid); end
        vecs++; if (last_hs - first_hs !== 3) begin errs++; $display("FAIL rd_bubbles: span %0d want 3", last_hs - first_hs); end
        vecs++; if (bus.ctrl_rdone_o !== 1'b1 || bus.rd_tvalid_o !== 1'b0) begin errs++; $display("FAIL rd_done: rdone=%b tvalid=%b want 1/0", bus.ctrl_rdone_o, bus.rd_tvalid_o); end
        @(posedge clk); #1;
        vecs++; if (bus.ctrl_rdone_o !== 1'b0) begin errs++; $display("FAIL rd_done_pulse: got %b want 0", bus.ctrl_rdone_o); end
    endtask

    task automatic test_stall();
        int rc;
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hA0000000 + i; sbuf[i] = 4'hF; end
        do_write(32'h100, 32'd32, 1'b0);
        @(posedge clk); #1;
        rc = rdone_cnt;
        do_read(32'h100, 32'd32, 1'b1);
        @(posedge clk); #1;
        vecs++; if (n_rd !== 8) begin errs++; $display("FAIL stall_beats: got %0d want 8", n_rd); end
        for (int i = 0; i < 8; i++) begin
            vecs++; if (rbuf[i] !== 32'hA0000000 + i) begin errs++; $display("FAIL stall_data[%0d]: got %h want %h", i, rbuf[i], 32'hA0000000 + i); end
        end
        vecs++; if (viol !== 0) begin errs++; $display("FAIL stall_hold: %0d unstable stalls, want 0", viol); end
        vecs++; if (rdone_cnt - rc !== 1) begin errs++; $display("FAIL stall_rdone: got %0d pulses want 1", rdone_cnt - rc); end
    endtask

    task automatic test_strobe();
        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
        do_write(32'h200, 32'd4, 1'b0);
        @(posedge clk); #1;
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        do_write(32'h200, 32'd4, 1'b1);
        @(posedge clk); #1;
        do_read(32'h200, 32'd4, 1'b0);
        @(posedge clk); #1;
        vecs++; if (rbuf[0] !== 32'hFFBBFFDD) begin errs++; $display("FAIL strobe: got %h want ffbbffdd", rbuf[0]); end
    endtask

    task automatic test_wrap();
        wbuf[0] = 32'h5A5A0001; wbuf[1] = 32'h5A5A0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(32'hFFC, 32'd8, 1'b0);
        @(posedge clk); #1;
        do_read(32'h0, 32'd4, 1'b0);
        @(posedge clk); #1;
        vecs++; if (rbuf[0] !== 32'h5A5A0002) begin errs++; $display("FAIL wrap_w0: got %h want 5a5a0002", rbuf[0]); end
        do_read(32'hFFC, 32'd8, 1'b0);
        @(posedge clk); #1;
        vecs++; if (rbuf[0] !== 32'h5A5A0001 || rbuf[1] !== 32'h5A5A0002) begin errs++; $display("FAIL wrap_rd: got %h %h want 5a5a0001 5a5a0002", rbuf[0], rbuf[1]); end
    endtask

    task automatic test_concurrent();
        int  rc, wc;
        bit  quiet;
        rc = rdone_cnt; wc = wdone_cnt;
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0000000 + i; sbuf[i] = 4'hF; end
        fork
            do_write(32'h300, 32'd16, 1'b0);
            do_read(32'h40, 32'd16, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.ctrl_raddr_offset_i = 32'h100;
                bus.ctrl_rxfer_size_i   = 32'd32;
                bus.ctrl_rstart_i       = 1'b1;
                @(posedge clk); #1;
                bus.ctrl_rstart_i = 1'b0;
            end
        join
        vecs++; if (n_rd !== 4) begin errs++; $display("FAIL conc_beats: got %0d want 4", n_rd); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (rbuf[i] !== 32'h11111111 * (i + 1)) begin errs++; $display("FAIL conc_data[%0d]: got %h want %h", i, rbuf[i], 32'h11111111 * (i + 1)); end
        end
        quiet = 1'b1;
        bus.rd_tready_i = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.rd_tvalid_o !== 1'b0) quiet = 1'b0;
        end
        bus.rd_tready_i = 1'b0;
        vecs++; if (quiet !== 1'b1) begin errs++; $display("FAIL conc_ignored_start: tvalid seen after done, want none"); end
        vecs++; if (rdone_cnt - rc !== 1) begin errs++; $display("FAIL conc_rdone: got %0d pulses want 1", rdone_cnt - rc); end
        vecs++; if (wdone_cnt - wc !== 1) begin errs++; $display("FAIL conc_wdone: got %0d pulses want 1", wdone_cnt - wc); end
        do_read(32'h300, 32'd16, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            vecs++; if (rbuf[i] !== 32'hC0000000 + i) begin errs++; $display("FAIL conc_wr_data[%0d]: got %h want %h", i, rbuf[i], 32'hC0000000 + i); end
        end
    endtask

    task automatic test_zero_len();
        bus.ctrl_raddr_offset_i = 32'h40; bus.ctrl_rxfer_size_i = 32'd3;
        bus.ctrl_waddr_offset_i = 32'h40; bus.ctrl_wxfer_size_i = 32'd0;
        bus.ctrl_rstart_i = 1'b1; bus.ctrl_wstart_i = 1'b1;
        @(posedge clk); #1;
        bus.ctrl_rstart_i = 1'b0; bus.ctrl_wstart_i = 1'b0;
        vecs++; if (bus.ctrl_rdone_o !== 1'b0 || bus.ctrl_wdone_o !== 1'b0) begin errs++; $display("FAIL zero_early: rdone=%b wdone=%b want 0/0", bus.ctrl_rdone_o, bus.ctrl_wdone_o); end
        @(posedge clk); #1;
        vecs++; if (bus.ctrl_rdone_o !== 1'b1 || bus.ctrl_wdone_o !== 1'b1) begin errs++; $display("FAIL zero_done: rdone=%b wdone=%b want 1/1", bus.ctrl_rdone_o, bus.ctrl_wdone_o); end
        vecs++; if (bus.rd_tvalid_o !== 1'b0 || bus.wr_tready_o !== 1'b0) begin errs++; $display("FAIL zero_nostream: tvalid=%b wready=%b want 0/0", bus.rd_tvalid_o, bus.wr_tready_o); end
        @(posedge clk); #1;
        vecs++; if (bus.ctrl_rdone_o !== 1'b0 || bus.ctrl_wdone_o !== 1'b0) begin errs++; $display("FAIL zero_pulse: rdone=%b wdone=%b want 0/0", bus.ctrl_rdone_o, bus.ctrl_wdone_o); end
    endtask

    task automatic test_reset_mid_read();
        int rc;
        bus.ctrl_raddr_offset_i = 32'h100;
        bus.ctrl_rxfer_size_i   = 32'd32;
        bus.ctrl_rstart_i       = 1'b1;
        bus.rd_tready_i         = 1'b1;
        @(posedge clk); #1;
        bus.ctrl_rstart_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        vecs++; if (bus.rd_tvalid_o !== 1'b1 || bus.rd_tdata_o !== 32'hA0000002) begin errs++; $display("FAIL mid_beat3: tvalid=%b data=%h want 1/a0000002", bus.rd_tvalid_o, bus.rd_tdata_o); end
        rc = rdone_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        vecs++; if (bus.rd_tvalid_o !== 1'b0 || bus.rd_tdata_o !== 32'h0 || bus.rd_tlast_o !== 1'b0 || bus.ctrl_rdone_o !== 1'b0)
            begin errs++; $display("FAIL mid_reset_outs: tvalid=%b data=%h tlast=%b rdone=%b want all 0", bus.rd_tvalid_o, bus.rd_tdata_o, bus.rd_tlast_o, bus.ctrl_rdone_o); end
        reset = 1'b0;
        bus.rd_tready_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        vecs++; if (rdone_cnt !== rc || bus.rd_tvalid_o !== 1'b0) begin errs++; $display("FAIL mid_no_done: rdone pulses %0d tvalid=%b want 0/0", rdone_cnt - rc, bus.rd_tvalid_o); end
        do_read(32'h100, 32'd16, 1'b0);
        @(posedge clk); #1;
        vecs++; if (first_valid !== 2 || n_rd !== 4) begin errs++; $display("FAIL mid_fresh: latency %0d beats %0d want 2/4", first_valid, n_rd); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (rbuf[i] !== 32'hA0000000 + i) begin errs++; $display("FAIL mid_fresh_data[%0d]: got %h want %h", i, rbuf[i], 32'hA0000000 + i); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.ctrl_raddr_offset_i = 32'h0; bus.ctrl_rxfer_size_i = 32'h0; bus.ctrl_rstart_i = 1'b0;
        bus.rd_tready_i = 1'b0;
        bus.ctrl_waddr_offset_i = 32'h0; bus.ctrl_wxfer_size_i = 32'h0; bus.ctrl_wstart_i = 1'b0;
        bus.ctrl_wstrb_msk_en_i = 1'b0; bus.wr_tdata_i = 32'h0; bus.wr_tvalid_i = 1'b0;
        bus.wr_tstrb_msk_i = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_write_read();
        test_stall();
        test_strobe();
        test_wrap();
        test_concurrent();
        test_zero_len();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
